// File: rtl/pong_pkg.sv
// Shared types and widths for the ping-pong match controller.
// Contents: game-state and winner encodings, score/time widths, the packed
// button bundle, and a helper that picks the winner from two scores.
package pong_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned TIME_W  = 6;

  typedef enum logic [1:0] {
    P1_SERVE = 2'd0,
    P2_SERVE = 2'd1,
    PLAYING  = 2'd2,
    DONE     = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } winner_e;

  // One bit per player button, in port order.
  typedef struct packed {
    logic p1l;
    logic p1r;
    logic p2l;
    logic p2r;
  } buttons_t;

  // Winner at time-out: higher score wins, equal scores are a tie.
  function automatic winner_e score_winner(input logic [SCORE_W-1:0] s1,
                                           input logic [SCORE_W-1:0] s2);
    if (s1 > s2) begin
      return WIN_P1;
    end else if (s2 > s1) begin
      return WIN_P2;
    end else begin
      return WIN_TIE;
    end
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts enabled clk cycles and pulses tick_c on the
// last cycle of each TICKS_PER_SEC period. The count holds while disabled.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (count -> 0)
//   en          - count enable
//   tick_c      - combinational 1-cycle pulse, high when en and count is last
module sec_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = en && (cnt_q == CNT_LAST);

  // Phase counter; wraps on the tick, holds when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Central game controller: serve/playing/done FSM, both scores and the
// countdown match timer. Emits a 1-cycle ball_launch on every serve.
// Optional feature macro: AUTO_SERVE_EN (serve automatically after
// AUTO_SERVE_SEC seconds idle in a serve state; parameter exists only then).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   p1l/p1r/p2l/p2r     - synchronised button levels
//   miss_p1/miss_p2     - 1-cycle pulses, ball passed that player's board
//   game_state          - 0 P1_SERVE, 1 P2_SERVE, 2 PLAYING, 3 DONE
//   p1_score/p2_score   - points
//   time_cnt            - remaining seconds
//   ball_launch         - 1-cycle pulse on serve -> PLAYING
//   winner              - 00 none, 01 p1, 10 p2, 11 tie (valid in DONE)
module match_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC  = 50000000,
  parameter int unsigned MATCH_TIME     = 60,
  parameter int unsigned WIN_SCORE      = 7
`ifdef AUTO_SERVE_EN
  ,
  parameter int unsigned AUTO_SERVE_SEC = 3
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p1l,
  input  logic               p1r,
  input  logic               p2l,
  input  logic               p2r,
  input  logic               miss_p1,
  input  logic               miss_p2,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [TIME_W-1:0]  time_cnt,
  output logic               ball_launch,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] WIN_S  = SCORE_W'(WIN_SCORE);
  localparam logic [TIME_W-1:0]  TIME_0 = TIME_W'(MATCH_TIME);

  game_state_e        state_q, state_d;
  winner_e            winner_q, winner_d;
  logic [SCORE_W-1:0] p1_d, p2_d;
  logic [TIME_W-1:0]  time_d;
  logic               launch_d;

  buttons_t btn_c, prev_q, press_c;
  logic     hist_valid_q;
  logic     presc_en_c, tick_c, auto_serve_c;

  assign game_state = state_q;
  assign winner     = winner_q;

  // Rising-edge detect. hist_valid_q masks the first cycle after reset so a
  // button held through reset must be released and pressed again.
  assign btn_c   = buttons_t'({p1l, p1r, p2l, p2r});
  assign press_c = hist_valid_q ? buttons_t'(btn_c & ~prev_q) : buttons_t'('0);

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en_c),
    .tick_c(tick_c)
  );

`ifdef AUTO_SERVE_EN
  localparam int unsigned SERVE_W = $clog2(AUTO_SERVE_SEC + 1);
  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(AUTO_SERVE_SEC - 1);

  logic               serving_c;
  logic [SERVE_W-1:0] serve_cnt_q;

  assign serving_c    = (state_q == P1_SERVE) || (state_q == P2_SERVE);
  assign presc_en_c   = (state_q == PLAYING) || serving_c;
  assign auto_serve_c = serving_c && tick_c && (serve_cnt_q == SERVE_LAST);

  // Seconds spent idle in a serve state; held at 0 outside serve states so
  // every entry into a serve starts from zero.
  always_ff @(posedge clk) begin
    if (reset || !serving_c) begin
      serve_cnt_q <= '0;
    end else if (tick_c) begin
      serve_cnt_q <= serve_cnt_q + SERVE_W'(1);
    end
  end
`else
  assign presc_en_c   = (state_q == PLAYING);
  assign auto_serve_c = 1'b0;
`endif

  // Next-state, score, timer and launch logic.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    p1_d     = p1_score;
    p2_d     = p2_score;
    time_d   = time_cnt;
    launch_d = 1'b0;

    case (state_q)
      P1_SERVE: begin
        if (press_c.p1l || press_c.p1r || auto_serve_c) begin
          state_d  = PLAYING;
          launch_d = 1'b1;
        end
      end

      P2_SERVE: begin
        if (press_c.p2l || press_c.p2r || auto_serve_c) begin
          state_d  = PLAYING;
          launch_d = 1'b1;
        end
      end

      PLAYING: begin
        // miss_p1 has priority when both misses arrive together; the loser serves.
        if (miss_p1) begin
          p2_d    = p2_score + SCORE_W'(1);
          state_d = P1_SERVE;
        end else if (miss_p2) begin
          p1_d    = p1_score + SCORE_W'(1);
          state_d = P2_SERVE;
        end

        if (tick_c) begin
          time_d = time_cnt - TIME_W'(1);
        end

        // Scores are below WIN_S on entry to PLAYING, so equality means this
        // cycle's point won the match. Time-out uses the updated scores.
        if (p2_d == WIN_S) begin
          state_d  = DONE;
          winner_d = WIN_P2;
        end else if (p1_d == WIN_S) begin
          state_d  = DONE;
          winner_d = WIN_P1;
        end else if (tick_c && (time_d == '0)) begin
          state_d  = DONE;
          winner_d = score_winner(p1_d, p2_d);
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = P1_SERVE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= P1_SERVE;
      winner_q     <= WIN_NONE;
      p1_score     <= '0;
      p2_score     <= '0;
      time_cnt     <= TIME_0;
      ball_launch  <= 1'b0;
      prev_q       <= '0;
      hist_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      p1_score     <= p1_d;
      p2_score     <= p2_d;
      time_cnt     <= time_d;
      ball_launch  <= launch_d;
      prev_q       <= btn_c;
      hist_valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer. Two instances share all inputs:
// dut_a (MATCH_TIME=60) and dut_b (MATCH_TIME=2), both TICKS_PER_SEC=4,
// WIN_SCORE=7. Inputs change and outputs are sampled 1 time unit after the
// rising edge.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       p1l, p1r, p2l, p2r, miss_p1, miss_p2;

  logic [1:0] gs_a, win_a, gs_b, win_b;
  logic [3:0] s1_a, s2_a, s1_b, s2_b;
  logic [5:0] t_a, t_b;
  logic       bl_a, bl_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  match_sequencer #(
    .TICKS_PER_SEC(4),
    .MATCH_TIME   (60),
    .WIN_SCORE    (7)
  ) dut_a (
    .clk        (clk),
    .reset      (reset),
    .p1l        (p1l),
    .p1r        (p1r),
    .p2l        (p2l),
    .p2r        (p2r),
    .miss_p1    (miss_p1),
    .miss_p2    (miss_p2),
    .game_state (gs_a),
    .p1_score   (s1_a),
    .p2_score   (s2_a),
    .time_cnt   (t_a),
    .ball_launch(bl_a),
    .winner     (win_a)
  );

  match_sequencer #(
    .TICKS_PER_SEC(4),
    .MATCH_TIME   (2),
    .WIN_SCORE    (7)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .p1l        (p1l),
    .p1r        (p1r),
    .p2l        (p2l),
    .p2r        (p2r),
    .miss_p1    (miss_p1),
    .miss_p2    (miss_p2),
    .game_state (gs_b),
    .p1_score   (s1_b),
    .p2_score   (s2_b),
    .time_cnt   (t_b),
    .ball_launch(bl_b),
    .winner     (win_b)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Two reset cycles then one idle cycle so the next edge can see presses.
  task automatic do_reset();
    reset = 1'b1;
    {p1l, p1r, p2l, p2r, miss_p1, miss_p2} = 6'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // dut_b: reach 1:1 with 2 PLAYING cycles, serve, then 5 more PLAYING cycles.
  // Prescaler phase afterwards is 3, time_cnt is 1: the next edge is the final tick.
  task automatic reach_last_tick_b();
    do_reset();
    p1r = 1'b1;                 step(1);  // serve
    p1r = 1'b0; miss_p2 = 1'b1; step(1);  // p1 scores
    miss_p2 = 1'b0; p2l = 1'b1; step(1);  // p2 serves
    p2l = 1'b0; miss_p1 = 1'b1; step(1);  // p2 scores
    miss_p1 = 1'b0; p1r = 1'b1; step(1);  // p1 serves
    p1r = 1'b0;
    check_eq("b_state_after_serve", gs_b, 2);
    check_eq("b_scores_1_1", {s1_b, s2_b}, 8'h11);
    step(2);
    check_eq("b_time_one", t_b, 1);
    step(3);
    check_eq("b_still_playing", gs_b, 2);
  endtask

  initial begin
    do_reset();
    check_eq("rst_state", gs_a, 0);
    check_eq("rst_p1_score", s1_a, 0);
    check_eq("rst_p2_score", s2_a, 0);
    check_eq("rst_time", t_a, 60);
    check_eq("rst_time_b", t_b, 2);
    check_eq("rst_launch", bl_a, 0);
    check_eq("rst_winner", win_a, 0);

`ifdef AUTO_SERVE_EN
    // Three ticks of 4 cycles idle in P1_SERVE trigger the automatic serve.
    step(10);
    check_eq("auto_not_yet", gs_a, 0);
    step(1);
    check_eq("auto_serve_state", gs_a, 2);
    check_eq("auto_serve_launch", bl_a, 1);
    check_eq("auto_time_held", t_a, 60);
`else
    // p2 press ignored in P1_SERVE; p1 press serves with a 1-cycle launch.
    p2l = 1'b1; step(1); p2l = 1'b0;
    check_eq("p2_in_p1serve_state", gs_a, 0);
    check_eq("p2_in_p1serve_launch", bl_a, 0);
    p1r = 1'b1; step(1); p1r = 1'b0;
    check_eq("serve_state", gs_a, 2);
    check_eq("serve_launch", bl_a, 1);
    step(1);
    check_eq("launch_one_cycle", bl_a, 0);

    // 8 PLAYING cycles -> two ticks.
    step(6);
    check_eq("time_before_2nd_tick", t_a, 59);
    step(1);
    check_eq("time_after_8_cycles", t_a, 58);

    // 9th PLAYING cycle carries the miss; phase 1 is held through P2_SERVE.
    miss_p2 = 1'b1; step(1); miss_p2 = 1'b0;
    check_eq("miss_p2_state", gs_a, 1);
    check_eq("miss_p2_score", s1_a, 1);
    step(10);
    check_eq("serve_time_frozen", t_a, 58);
    check_eq("serve_wait_state", gs_a, 1);
    p2l = 1'b1; step(1); p2l = 1'b0;
    check_eq("p2_serve_launch", bl_a, 1);
    step(2);
    check_eq("phase_held_no_tick", t_a, 58);
    step(1);
    check_eq("phase_held_tick", t_a, 57);

    // Seven p1 points win the match.
    do_reset();
    p1r = 1'b1; step(1); p1r = 1'b0;
    for (int i = 0; i < 7; i++) begin
      miss_p2 = 1'b1; step(1); miss_p2 = 1'b0;
      check_eq("p1_score_run", s1_a, 32'(i + 1));
      if (i < 6) begin
        check_eq("p1_point_state", gs_a, 1);
        p2l = 1'b1; step(1); p2l = 1'b0;
      end
    end
    check_eq("win_state", gs_a, 3);
    check_eq("win_winner", win_a, 1);
    miss_p1 = 1'b1; step(1); miss_p1 = 1'b0;
    check_eq("done_miss_ignored", s2_a, 0);
    p1r = 1'b1; step(1); p1r = 1'b0;
    check_eq("done_no_launch", bl_a, 0);
    check_eq("done_absorbing", gs_a, 3);
    step(8);
    check_eq("done_time_frozen", t_a, 59);

    // Time-out at 1:1 -> tie.
    reach_last_tick_b();
    step(1);
    check_eq("timeout_state", gs_b, 3);
    check_eq("timeout_tie", win_b, 3);
    check_eq("timeout_time_zero", t_b, 0);

    // Miss on the final tick counts before the winner is decided.
    reach_last_tick_b();
    miss_p1 = 1'b1; step(1); miss_p1 = 1'b0;
    check_eq("final_tick_state", gs_b, 3);
    check_eq("final_tick_p2_score", s2_b, 2);
    check_eq("final_tick_p1_score", s1_b, 1);
    check_eq("final_tick_winner", win_b, 2);

    // Simultaneous misses: miss_p1 wins.
    do_reset();
    p1r = 1'b1; step(1); p1r = 1'b0;
    miss_p1 = 1'b1; miss_p2 = 1'b1; step(1); miss_p1 = 1'b0; miss_p2 = 1'b0;
    check_eq("both_miss_p2_score", s2_a, 1);
    check_eq("both_miss_p1_score", s1_a, 0);
    check_eq("both_miss_state", gs_a, 0);

    // Reset mid-match with p1r held; the held button must not serve.
    p1r = 1'b1; step(1);
    check_eq("rehold_serve_state", gs_a, 2);
    reset = 1'b1; step(2); reset = 1'b0;
    check_eq("midrst_state", gs_a, 0);
    check_eq("midrst_p2_score", s2_a, 0);
    check_eq("midrst_time", t_a, 60);
    check_eq("midrst_launch", bl_a, 0);
    step(3);
    check_eq("held_no_serve_state", gs_a, 0);
    check_eq("held_no_serve_launch", bl_a, 0);
    p1r = 1'b0; step(1);
    p1r = 1'b1; step(1); p1r = 1'b0;
    check_eq("repress_serve_state", gs_a, 2);
    check_eq("repress_serve_launch", bl_a, 1);

    // Without auto-serve a serve waits indefinitely.
    do_reset();
    step(100);
    check_eq("no_auto_serve_state", gs_a, 0);
    check_eq("no_auto_serve_launch", bl_a, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
